// File: rtl/fp_norm_round_if.sv
// Handshake and data bundle between the FP multiplier datapath and fp_norm_round.
// master drives the request side, slave is the normalise/round stage.
interface fp_norm_round_if #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 24
);
    logic                     start;
    logic                     sign_in;
    logic signed [EXP_W-1:0]  exp_in;
    logic [2*MANT_W-1:0]      prod_in;
    logic                     nan_in;
    logic                     inf_in;
    logic                     zero_in;
    logic [31:0]              result;
    logic                     done;
    logic                     busy;
    logic                     overflow;
    logic                     underflow;
    logic                     inexact;

    modport master (
        output start, sign_in, exp_in, prod_in, nan_in, inf_in, zero_in,
        input  result, done, busy, overflow, underflow, inexact
    );

    modport slave (
        input  start, sign_in, exp_in, prod_in, nan_in, inf_in, zero_in,
        output result, done, busy, overflow, underflow, inexact
    );
endinterface

// File: rtl/fp_norm_round.sv
// Post-multiply normalise / round / range-check / pack stage of the FP32 multiplier.
// FP_RNE_EN defined: round-to-nearest-even; undefined: truncate (inexact still reported).
module fp_norm_round #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_norm_round_if.slave bus
);
    localparam int PW = 2 * MANT_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_PACK  = 2'd3;

    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_SAT  = EXP_W'(255);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;

    logic [1:0]              state_q, state_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic [PW-1:0]           prod_q, prod_d;
    logic                    nan_q, nan_d;
    logic                    inf_q, inf_d;
    logic                    zero_q, zero_d;
    logic [MANT_W-1:0]       mant_q, mant_d;
    logic                    g_q, g_d;
    logic                    s_q, s_d;
    logic                    rnd_inx_q, rnd_inx_d;
    logic [31:0]             result_q, result_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    inexact_q, inexact_d;

    logic                    inc;
    logic [MANT_W:0]         sum;

`ifdef FP_RNE_EN
    assign inc = g_q & (s_q | mant_q[0]);
`else
    assign inc = 1'b0;
`endif
    assign sum = {1'b0, mant_q} + {{MANT_W{1'b0}}, inc};

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        prod_d    = prod_q;
        nan_d     = nan_q;
        inf_d     = inf_q;
        zero_d    = zero_q;
        mant_d    = mant_q;
        g_d       = g_q;
        s_d       = s_q;
        rnd_inx_d = rnd_inx_q;
        result_d  = result_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        inexact_d = inexact_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sign_d  = bus.sign_in;
                    exp_d   = bus.exp_in;
                    prod_d  = bus.prod_in;
                    nan_d   = bus.nan_in;
                    inf_d   = bus.inf_in;
                    zero_d  = bus.zero_in;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (prod_q[PW-1]) begin
                    mant_d = prod_q[PW-1:MANT_W];
                    g_d    = prod_q[MANT_W-1];
                    s_d    = |prod_q[MANT_W-2:0];
                    exp_d  = exp_q + EXP_ONE;
                end else begin
                    mant_d = prod_q[PW-2:MANT_W-1];
                    g_d    = prod_q[MANT_W-2];
                    s_d    = |prod_q[MANT_W-3:0];
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                // Rounding all-ones up carries out: renormalise to 1.0 and bump the exponent.
                if (sum[MANT_W]) begin
                    mant_d = {1'b1, {(MANT_W-1){1'b0}}};
                    exp_d  = exp_q + EXP_ONE;
                end else begin
                    mant_d = sum[MANT_W-1:0];
                end
                rnd_inx_d = g_q | s_q;
                state_d   = S_PACK;
            end
            default: begin
                ovf_d     = 1'b0;
                unf_d     = 1'b0;
                inexact_d = 1'b0;
                if (nan_q) begin
                    result_d = 32'h7FC0_0000;
                end else if (inf_q) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                end else if (zero_q) begin
                    result_d = {sign_q, 31'd0};
                end else if (exp_q >= EXP_SAT) begin
                    result_d  = {sign_q, 8'hFF, 23'd0};
                    ovf_d     = 1'b1;
                    inexact_d = 1'b1;
                end else if (exp_q <= EXP_ZERO) begin
                    result_d  = {sign_q, 31'd0};
                    unf_d     = 1'b1;
                    inexact_d = 1'b1;
                end else begin
                    result_d  = {sign_q, exp_q[7:0], mant_q[MANT_W-2:0]};
                    inexact_d = rnd_inx_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            prod_q    <= '0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
            mant_q    <= '0;
            g_q       <= 1'b0;
            s_q       <= 1'b0;
            rnd_inx_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            prod_q    <= prod_d;
            nan_q     <= nan_d;
            inf_q     <= inf_d;
            zero_q    <= zero_d;
            mant_q    <= mant_d;
            g_q       <= g_d;
            s_q       <= s_d;
            rnd_inx_q <= rnd_inx_d;
            result_q  <= result_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            inexact_q <= inexact_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.inexact   = inexact_q;
endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: directed cases, handshake/reset corners, random ops
// checked against an arithmetic reference model.
module tb_fp_norm_round;
    localparam int EXP_W  = 10;
    localparam int MANT_W = 24;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          issue;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_norm_round_if #(.EXP_W(EXP_W), .MANT_W(MANT_W)) bus ();
    fp_norm_round #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t sbq[$];
    int   total    = 0;
    int   passed   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic ovf, input logic unf,
                                input logic inx);
        exp_t r;
        r.res = res; r.ovf = ovf; r.unf = unf; r.inx = inx; r.issue = 0;
        return r;
    endfunction

    // Reference: value = prod * 2^(exp-127-46); keep 24 significant bits, remainder decides rounding.
    function automatic exp_t model(input bit s, input int e, input longint unsigned p,
                                   input bit nan, input bit inf, input bit zero);
        exp_t r;
        int sh;
        longint unsigned m, rem, half;
        r = mk(32'd0, 1'b0, 1'b0, 1'b0);
        if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
        else sh = 23;
        m    = p >> sh;
        rem  = p - (m << sh);
        half = 64'd1 << (sh - 1);
        r.inx = (rem != 0);
`ifdef FP_RNE_EN
        if (rem > half || (rem == half && m[0])) m = m + 1;
        if (m == (64'd1 << 24)) begin m = m >> 1; e = e + 1; end
`endif
        if (nan)       begin r.res = 32'h7FC00000;           r.inx = 0; end
        else if (inf)  begin r.res = {s, 8'hFF, 23'd0};      r.inx = 0; end
        else if (zero) begin r.res = {s, 31'd0};             r.inx = 0; end
        else if (e >= 255) begin r.res = {s, 8'hFF, 23'd0};  r.ovf = 1; r.inx = 1; end
        else if (e <= 0)   begin r.res = {s, 31'd0};         r.unf = 1; r.inx = 1; end
        else r.res = {s, 8'(e), 23'(m)};
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t ex;
        if (rst_n && bus.done) begin
            done_cnt++;
            if (sbq.size() == 0) check("unexpected_done", 1, 0);
            else begin
                ex = sbq.pop_front();
                check("result",    bus.result,    ex.res);
                check("overflow",  bus.overflow,  ex.ovf);
                check("underflow", bus.underflow, ex.unf);
                check("inexact",   bus.inexact,   ex.inx);
                check("latency",   cyc - ex.issue, 3);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the next negedge with start low.
    task automatic send(input bit s, input int e, input longint unsigned p, input bit nan,
                        input bit inf, input bit zero, input exp_t ex);
        bus.start   = 1'b1;
        bus.sign_in = s;
        bus.exp_in  = EXP_W'(e);
        bus.prod_in = 48'(p);
        bus.nan_in  = nan;
        bus.inf_in  = inf;
        bus.zero_in = zero;
        ex.issue    = cyc + 1;
        sbq.push_back(ex);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 20) begin @(negedge clk); n++; end
        if (!bus.done) check("done_timeout", 0, 1);
    endtask

    task automatic run(input bit s, input int e, input longint unsigned p, input bit nan,
                       input bit inf, input bit zero, input exp_t ex);
        send(s, e, p, nan, inf, zero, ex);
        wait_done();
        check("busy_in_done_cycle", bus.busy, 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        exp_t ex;
        longint unsigned p;
        int e;
        bit s, nan, inf, zero;

        rst_n = 1'b0;
        bus.start = 0; bus.sign_in = 0; bus.exp_in = '0; bus.prod_in = '0;
        bus.nan_in = 0; bus.inf_in = 0; bus.zero_in = 0;
        repeat (2) @(negedge clk);
        check("rst_result", bus.result, 0);
        check("rst_done",   bus.done,   0);
        check("rst_busy",   bus.busy,   0);
        check("rst_flags",  {bus.overflow, bus.underflow, bus.inexact}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 127, 48'h900000000000, 0, 0, 0, mk(32'h40100000, 0, 0, 0));
`ifdef FP_RNE_EN
        run(0, 127, 48'h7FFFFFC00000, 0, 0, 0, mk(32'h40000000, 0, 0, 1));
`else
        run(0, 127, 48'h7FFFFFC00000, 0, 0, 0, mk(32'h3FFFFFFF, 0, 0, 1));
`endif
        run(0, 127, 48'h400000400000, 0, 0, 0, mk(32'h3F800000, 0, 0, 1));
        run(0, 300, 48'h400000000000, 0, 0, 0, mk(32'h7F800000, 1, 0, 1));
        run(1, 0,   48'h400000000000, 0, 0, 0, mk(32'h80000000, 0, 1, 1));
        run(0, 127, 48'h400000000000, 1, 1, 0, mk(32'h7FC00000, 0, 0, 0));
        run(1, 127, 48'h400000000000, 0, 1, 0, mk(32'hFF800000, 0, 0, 0));
        run(1, 127, 48'h400000000000, 0, 0, 1, mk(32'h80000000, 0, 0, 0));

        // start pulsed while busy must be ignored
        d0 = done_cnt;
        send(0, 128, 48'h600000000000, 0, 0, 0, mk(32'h40400000, 0, 0, 0));
        bus.start = 1'b1; bus.prod_in = 48'h500000000000; bus.exp_in = EXP_W'(140);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (8) @(negedge clk);
        check("single_done_when_busy_start", done_cnt - d0, 1);

        // back-to-back: second start in the done cycle
        send(0, 127, 48'h900000000000, 0, 0, 0, mk(32'h40100000, 0, 0, 0));
        wait_done();
        send(1, 128, 48'h600000000000, 0, 0, 0, mk(32'hC0400000, 0, 0, 0));
        wait_done();
        @(negedge clk);

        // reset while in ROUND
        send(0, 127, 48'h600000000000, 0, 0, 0, mk(32'h3FC00000, 0, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy",   bus.busy,   0);
        check("midrst_done",   bus.done,   0);
        check("midrst_result", bus.result, 0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", done_cnt - d0, 0);

        for (int i = 0; i < 80; i++) begin
            s    = 1'($urandom);
            e    = int'($urandom_range(0, 420)) - 40;
            p    = (64'd1 << 46) + ({32'($urandom), 32'($urandom)} % (64'd3 << 46));
            if ($urandom_range(0, 3) == 0) p = p & ~((64'd1 << 21) - 1);
            if ($urandom_range(0, 5) == 0) p = p | ((64'd1 << 24) - 1);
            nan  = ($urandom_range(0, 15) == 0);
            inf  = ($urandom_range(0, 15) == 0);
            zero = ($urandom_range(0, 15) == 0);
            send(s, e, p, nan, inf, zero, model(s, e, p, nan, inf, zero));
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Post-multiply stage of the single-precision FP multiplier.
- Consumes the 48-bit mantissa product from the shift-add multiplier, plus the sign, the pre-biased exponent sum and special-case flags from the unpack/exponent logic.
- Normalizes, rounds, range-checks and packs the IEEE-754 single result through a 4-state FSM.
- Start/done handshake matches the multiplier's done_mul convention.

Parameters:
- EXP_W, 10: width of signed exponent input; must cover -512..511.
- MANT_W, 24: significand width including hidden bit; product is 2*MANT_W bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- sign_in  in  1  result sign (sa XOR sb)
- exp_in  in  EXP_W  signed ea+eb-127
- prod_in  in  48  unsigned mantissa product, valid range [2^46, 2^48)
- nan_in  in  1  result is NaN (upstream folds inf*0 into this)
- inf_in  in  1  an operand is infinite
- zero_in  in  1  an operand is zero
- result  out  32  packed IEEE single
- done  out  1  one-cycle completion pulse
- busy  out  1  high when state != IDLE
- overflow  out  1  exponent overflowed to infinity
- underflow  out  1  result flushed to zero
- inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Reset (async, rst_n=0): state IDLE; result, done, overflow, underflow, inexact all 0; internal registers 0. Applies at any point mid-operation; the in-flight operation is discarded.
- FSM states and transitions:
  - IDLE: on start, capture all inputs, go to NORM. Otherwise stay in IDLE.
  - NORM: if prod[47], mant=prod[47:24], G=prod[23], S=|prod[22:0], exp=exp_in+1. Else mant=prod[46:23], G=prod[22], S=|prod[21:0], exp unchanged. Go to ROUND.
  - ROUND: inc = G & (S | mant[0]); form 25-bit mant+inc. On carry-out, mant=0x800000 and exp+1. Record inexact = G|S. Go to PACK.
  - PACK: register result and flags, done<=1, go to IDLE.
- Latency: start sampled at edge 0; done high during the cycle after edge 3 (4 cycles).
- done is a single-cycle pulse. result and flags hold until the next PACK.
- start is ignored while busy.
- start asserted in the cycle done is high is accepted, because the FSM is already in IDLE (back-to-back operation).
- Pack priority:
  - nan_in → 0x7FC00000, flags 0.
  - inf_in → {sign,0xFF,0}, flags 0.
  - zero_in → {sign,0x00,0}, flags 0.
  - exp >= 255 (signed) → {sign,0xFF,0}, overflow=1, inexact=1.
  - exp <= 0 → {sign,0,0}, underflow=1, inexact=1 (no subnormals).
  - Otherwise {sign, exp[7:0], mant[22:0]}, inexact as computed.
- Exponent arithmetic is signed EXP_W bits. Increments cannot wrap for legal inputs (max 381+2).
- Product below 2^46 is illegal input; behaviour is unspecified.

Optional Feature:
- Macro: FP_RNE_EN.
- Defined: round-to-nearest-even as in ROUND above.
- Undefined: truncation, i.e. inc forced 0 and no renormalize carry. inexact is still G|S. Same state sequence and latency.

Test Plan:
- Normal value: exp_in=127, prod=0x900000000000, sign=0, start → 4 cycles later done=1, result=0x40100000 (2.25), flags 0, busy low after done.
- Rounding: exp_in=127, prod=0x7FFFFFC00000 → with FP_RNE_EN, result=0x40000000 with carry renormalize and inexact=1. Without FP_RNE_EN, result=0x3FFFFFFF, inexact=1. Second case prod=0x400000400000 (tie, even lsb) → 0x3F800000, inexact=1.
- Range: exp_in=300, prod=0x400000000000 → 0x7F800000, overflow=1. exp_in=0, sign=1, same prod → 0x80000000, underflow=1.
- Specials: nan_in=1 with inf_in=1 → 0x7FC00000. inf_in=1, sign=1 → 0xFF800000. zero_in=1, sign=1 → 0x80000000. All flags 0.
- Handshake: pulse start again while busy → ignored, only one done. start in the done cycle → second done exactly 4 cycles later with the new result.
- Reset: drop rst_n during ROUND → busy, done and result 0 immediately. After release, no done until a new start.
